// File: rtl/obuf_pkg.sv
// Shared types and helpers for the output pixel buffer.
package obuf_pkg;

  localparam int unsigned OBUF_DEPTH_DFLT = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } obuf_state_e;

  // LSB position of lane `lane` in a flattened bus of `width`-bit lanes.
  function automatic int unsigned lane_base(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  // True when n is a power of two; out-of-range checks vanish in that case.
  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/output_pixel_buf_if.sv
// Write/read/output bundle of the output pixel buffer.
interface output_pixel_buf_if
  import obuf_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = OBUF_DEPTH_DFLT,
  parameter int unsigned N_WR  = 3,
  parameter int unsigned N_RD  = 4
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                    I_OBUF_CLR;
  logic [N_WR-1:0]         I_OBUF_WR_EN;
  logic [N_WR*ADDR_W-1:0]  I_OBUF_WR_ADDR;
  logic [N_WR*PIX_W-1:0]   I_OBUF_WR_DATA;
  logic                    I_OBUF_RD_VALID;
  logic                    O_OBUF_RD_READY;
  logic [N_RD*ADDR_W-1:0]  I_OBUF_RD_ADDR;
  logic [N_RD*PIX_W-1:0]   O_OBUF_WDATA;
  logic                    O_OBUF_WDATA_VALID;
  logic                    I_OBUF_WDATA_READY;
  logic                    O_OBUF_CLR_BUSY;
  logic                    O_OBUF_ADDR_ERR;

  modport master (
    output I_OBUF_CLR, I_OBUF_WR_EN, I_OBUF_WR_ADDR, I_OBUF_WR_DATA,
    output I_OBUF_RD_VALID, I_OBUF_RD_ADDR, I_OBUF_WDATA_READY,
    input  O_OBUF_RD_READY, O_OBUF_WDATA, O_OBUF_WDATA_VALID,
    input  O_OBUF_CLR_BUSY, O_OBUF_ADDR_ERR
  );

  modport slave (
    input  I_OBUF_CLR, I_OBUF_WR_EN, I_OBUF_WR_ADDR, I_OBUF_WR_DATA,
    input  I_OBUF_RD_VALID, I_OBUF_RD_ADDR, I_OBUF_WDATA_READY,
    output O_OBUF_RD_READY, O_OBUF_WDATA, O_OBUF_WDATA_VALID,
    output O_OBUF_CLR_BUSY, O_OBUF_ADDR_ERR
  );

endinterface

// File: rtl/obuf_rd_lane.sv
// One read lane: same-cycle write forwarding and out-of-range zeroing.
module obuf_rd_lane
  import obuf_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = OBUF_DEPTH_DFLT,
  parameter int unsigned N_WR  = 3
) (
  input  logic [$clog2(DEPTH)-1:0]       rd_addr_i,
  input  logic [PIX_W-1:0]               mem_pix_i,
  input  logic [N_WR-1:0]                wr_en_i,
  input  logic [N_WR*$clog2(DEPTH)-1:0]  wr_addr_i,
  input  logic [N_WR*PIX_W-1:0]          wr_data_i,
  output logic [PIX_W-1:0]               pix_c,
  output logic                           oor_c
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic             fwd_hit_c;
  logic [PIX_W-1:0] fwd_pix_c;

  // Out-of-range only exists when DEPTH leaves unused address codes.
  if (is_pow2(DEPTH)) begin : g_pow2
    assign oor_c = 1'b0;
  end else begin : g_npow2
    assign oor_c = (rd_addr_i >= ADDR_W'(DEPTH));
  end

  // Highest matching enabled write lane wins; otherwise take the stored pixel.
  always_comb begin
    fwd_hit_c = 1'b0;
    fwd_pix_c = '0;
    pix_c     = mem_pix_i;
    for (int unsigned k = 0; k < N_WR; k++) begin
      if (wr_en_i[k] && (wr_addr_i[lane_base(k, ADDR_W) +: ADDR_W] == rd_addr_i)) begin
        fwd_hit_c = 1'b1;
        fwd_pix_c = wr_data_i[lane_base(k, PIX_W) +: PIX_W];
      end
    end
    if (oor_c) begin
      pix_c = '0;
    end else if (fwd_hit_c) begin
      pix_c = fwd_pix_c;
    end
  end

endmodule

// File: rtl/output_pixel_buf.sv
// Pixel output buffer: multi-lane pixel writes, gathered N_RD-pixel reads
// packed into one write-data word through a two-stage handshake pipeline.
module output_pixel_buf
  import obuf_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = OBUF_DEPTH_DFLT,
  parameter int unsigned N_WR  = 3,
  parameter int unsigned N_RD  = 4
) (
  input  logic              I_OBUF_HCLK,
  input  logic              I_OBUF_HRESET,
  output_pixel_buf_if.slave obuf
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  // Storage: no reset so it maps onto a register file / RAM.
  logic [PIX_W-1:0] mem_q [DEPTH];

  obuf_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic clr_we_c;
  logic idle_c;

  logic [N_WR-1:0]              wr_oor_c;
  logic [N_WR-1:0]              lane_we_c;
  logic [N_WR-1:0][ADDR_W-1:0]  wr_addr_c;
  logic [N_WR-1:0][PIX_W-1:0]   wr_pix_c;

  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr_c;
  logic [N_RD-1:0][PIX_W-1:0]   mem_pix_c;
  logic [N_RD-1:0][PIX_W-1:0]   rd_pix_c;
  logic [N_RD-1:0]              rd_oor_c;

  logic                         adv_c;
  logic                         rd_ready_c;
  logic                         accept_c;
  logic [N_RD*PIX_W-1:0]        pack_c;

  logic                         s1_valid_q, s1_valid_d;
  logic [N_RD-1:0][PIX_W-1:0]   s1_pix_q, s1_pix_d;
  logic [N_RD*PIX_W-1:0]        wdata_q, wdata_d;
  logic                         wdata_valid_q, wdata_valid_d;
  logic                         addr_err_q, addr_err_d;

  assign idle_c = (state_q == ST_IDLE);

  // Per-lane write unpacking and range check.
  for (genvar k = 0; k < N_WR; k++) begin : g_wr_lane
    assign wr_addr_c[k] = obuf.I_OBUF_WR_ADDR[lane_base(k, ADDR_W) +: ADDR_W];
    assign wr_pix_c[k]  = obuf.I_OBUF_WR_DATA[lane_base(k, PIX_W) +: PIX_W];
    if (is_pow2(DEPTH)) begin : g_pow2
      assign wr_oor_c[k] = 1'b0;
    end else begin : g_npow2
      assign wr_oor_c[k] = (wr_addr_c[k] >= ADDR_W'(DEPTH));
    end
  end

  // Writes land only in IDLE and only for in-range addresses.
  assign lane_we_c = {N_WR{idle_c}} & obuf.I_OBUF_WR_EN & ~wr_oor_c;

  // Read lanes: memory lookup plus forwarding of this cycle's writes.
  for (genvar j = 0; j < N_RD; j++) begin : g_rd_lane
    assign rd_addr_c[j] = obuf.I_OBUF_RD_ADDR[lane_base(j, ADDR_W) +: ADDR_W];
    assign mem_pix_c[j] = mem_q[rd_addr_c[j]];

    obuf_rd_lane #(
      .PIX_W (PIX_W),
      .DEPTH (DEPTH),
      .N_WR  (N_WR)
    ) u_rd_lane (
      .rd_addr_i (rd_addr_c[j]),
      .mem_pix_i (mem_pix_c[j]),
      .wr_en_i   (lane_we_c),
      .wr_addr_i (obuf.I_OBUF_WR_ADDR),
      .wr_data_i (obuf.I_OBUF_WR_DATA),
      .pix_c     (rd_pix_c[j]),
      .oor_c     (rd_oor_c[j])
    );
  end

  // Clear sweep FSM: CLR (re)starts the sweep from entry 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (obuf.I_OBUF_CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (obuf.I_OBUF_CLR) begin
          cnt_d = '0;
        end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Pack stage-1 pixels with lane 0 in the most significant slot.
  always_comb begin
    pack_c = '0;
    for (int unsigned j = 0; j < N_RD; j++) begin
      pack_c[lane_base(N_RD - 1 - j, PIX_W) +: PIX_W] = s1_pix_q[j];
    end
  end

  // Handshake pipeline: request -> stage 1 -> output word, stall-safe.
  always_comb begin
    adv_c         = !wdata_valid_q || obuf.I_OBUF_WDATA_READY;
    rd_ready_c    = idle_c && (!s1_valid_q || adv_c);
    accept_c      = obuf.I_OBUF_RD_VALID && rd_ready_c;
    s1_valid_d    = accept_c || (s1_valid_q && !adv_c);
    s1_pix_d      = accept_c ? rd_pix_c : s1_pix_q;
    wdata_valid_d = wdata_valid_q;
    wdata_d       = wdata_q;
    if (adv_c) begin
      wdata_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        wdata_d = pack_c;
      end
    end
    addr_err_d = addr_err_q
               || (accept_c && (|rd_oor_c))
               || (idle_c && (|(obuf.I_OBUF_WR_EN & wr_oor_c)));
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge I_OBUF_HCLK) begin
    if (I_OBUF_HRESET) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      s1_valid_q    <= 1'b0;
      wdata_q       <= '0;
      wdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s1_valid_q    <= s1_valid_d;
      wdata_q       <= wdata_d;
      wdata_valid_q <= wdata_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Stage-1 pixel data is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge I_OBUF_HCLK) begin
    s1_pix_q <= s1_pix_d;
  end

  // Memory write port: clear sweep, then lanes in order so the highest lane wins.
  always_ff @(posedge I_OBUF_HCLK) begin
    if (clr_we_c) begin
      mem_q[cnt_q] <= '0;
    end
    for (int unsigned k = 0; k < N_WR; k++) begin
      if (lane_we_c[k]) begin
        mem_q[wr_addr_c[k]] <= wr_pix_c[k];
      end
    end
  end

  assign obuf.O_OBUF_RD_READY    = rd_ready_c;
  assign obuf.O_OBUF_WDATA       = wdata_q;
  assign obuf.O_OBUF_WDATA_VALID = wdata_valid_q;
  assign obuf.O_OBUF_CLR_BUSY    = (state_q == ST_CLEAR);
  assign obuf.O_OBUF_ADDR_ERR    = addr_err_q;

endmodule

// File: tb/tb_output_pixel_buf.sv
// Scoreboard bench for output_pixel_buf (DEPTH 64) plus a DEPTH 48 instance.
module tb_output_pixel_buf;
  import obuf_pkg::*;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned N_WR   = 3;
  localparam int unsigned N_RD   = 4;
  localparam int unsigned ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [PIX_W-1:0]     mdl [DEPTH];
  logic [N_RD*PIX_W-1:0] sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  output_pixel_buf_if #(.PIX_W(PIX_W), .DEPTH(DEPTH), .N_WR(N_WR), .N_RD(N_RD)) bus ();
  output_pixel_buf_if #(.PIX_W(PIX_W), .DEPTH(48),    .N_WR(N_WR), .N_RD(N_RD)) bus48 ();

  output_pixel_buf #(.PIX_W(PIX_W), .DEPTH(DEPTH), .N_WR(N_WR), .N_RD(N_RD)) dut (
    .I_OBUF_HCLK   (clk),
    .I_OBUF_HRESET (rst),
    .obuf          (bus)
  );

  output_pixel_buf #(.PIX_W(PIX_W), .DEPTH(48), .N_WR(N_WR), .N_RD(N_RD)) dut48 (
    .I_OBUF_HCLK   (clk),
    .I_OBUF_HRESET (rst),
    .obuf          (bus48)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every valid word must equal the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.O_OBUF_WDATA_VALID) begin
      if (sb_q.size() == 0) begin
        chk("extra_word_valid", 64'(bus.O_OBUF_WDATA_VALID), 64'd0);
      end else begin
        chk("wdata", 64'(bus.O_OBUF_WDATA), 64'(sb_q[0]));
        if (bus.I_OBUF_WDATA_READY) void'(sb_q.pop_front());
      end
    end
  end

  function automatic logic [N_RD*PIX_W-1:0] exp_word(input logic [N_RD*ADDR_W-1:0] addrs);
    logic [N_RD*PIX_W-1:0] w;
    w = '0;
    for (int j = 0; j < N_RD; j++) begin
      w[(N_RD-1-j)*PIX_W +: PIX_W] = mdl[addrs[j*ADDR_W +: ADDR_W]];
    end
    return w;
  endfunction

  task automatic set_wr(input int k, input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
    bus.I_OBUF_WR_EN[k]                   = 1'b1;
    bus.I_OBUF_WR_ADDR[k*ADDR_W +: ADDR_W] = a;
    bus.I_OBUF_WR_DATA[k*PIX_W +: PIX_W]   = d;
  endtask

  task automatic clear_wr();
    bus.I_OBUF_WR_EN = '0;
  endtask

  // Model the write edge: lanes in ascending order, highest lane wins.
  task automatic apply_writes();
    for (int k = 0; k < N_WR; k++) begin
      if (bus.I_OBUF_WR_EN[k]) mdl[bus.I_OBUF_WR_ADDR[k*ADDR_W +: ADDR_W]] = bus.I_OBUF_WR_DATA[k*PIX_W +: PIX_W];
    end
  endtask

  // Issue one read request; expectation is pushed in the accepting cycle.
  task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                    input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3);
    bit ok;
    ok = 1'b0;
    bus.I_OBUF_RD_ADDR  = {a3, a2, a1, a0};
    bus.I_OBUF_RD_VALID = 1'b1;
    for (int w = 0; w < 100 && !ok; w++) begin
      @(negedge clk);
      if (bus.O_OBUF_RD_READY) begin
        ok = 1'b1;
        sb_q.push_back(exp_word({a3, a2, a1, a0}));
      end
      tick();
    end
    if (!ok) chk("rd_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int w = 0; w < 50 && sb_q.size() > 0; w++) tick();
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  // Count busy cycles from now; optionally pulse CLR in busy cycle clr_at.
  task automatic measure_busy(input int clr_at, input int exp_n, input string tag);
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (bus.O_OBUF_CLR_BUSY && n < 200) begin
      if (bus.O_OBUF_RD_READY) rdy_seen = 1'b1;
      bus.I_OBUF_CLR = (n == clr_at);
      n++;
      tick();
    end
    bus.I_OBUF_CLR = 1'b0;
    chk({tag, "_busy_len"}, 64'(n), 64'(exp_n));
    chk({tag, "_rd_ready_in_clear"}, 64'(rdy_seen), 64'd0);
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    bus.I_OBUF_CLR = 1'b0;         bus48.I_OBUF_CLR = 1'b0;
    bus.I_OBUF_WR_EN = '0;         bus48.I_OBUF_WR_EN = '0;
    bus.I_OBUF_WR_ADDR = '0;       bus48.I_OBUF_WR_ADDR = '0;
    bus.I_OBUF_WR_DATA = '0;       bus48.I_OBUF_WR_DATA = '0;
    bus.I_OBUF_RD_VALID = 1'b0;    bus48.I_OBUF_RD_VALID = 1'b0;
    bus.I_OBUF_RD_ADDR = '0;       bus48.I_OBUF_RD_ADDR = '0;
    bus.I_OBUF_WDATA_READY = 1'b1; bus48.I_OBUF_WDATA_READY = 1'b1;
    foreach (mdl[i]) mdl[i] = 8'hxx;

    // Reset and the sweep it launches
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wdata",       64'(bus.O_OBUF_WDATA), 64'd0);
    chk("rst_wdata_valid", 64'(bus.O_OBUF_WDATA_VALID), 64'd0);
    chk("rst_addr_err",    64'(bus.O_OBUF_ADDR_ERR), 64'd0);
    chk("rst_clr_busy",    64'(bus.O_OBUF_CLR_BUSY), 64'd1);
    measure_busy(-1, 64, "rst");
    rd(6'd0, 6'd1, 6'd2, 6'd3);
    bus.I_OBUF_RD_VALID = 1'b0;
    drain();

    // Basic pack with two-cycle latency
    set_wr(0, 6'd5, 8'hAA); set_wr(1, 6'd6, 8'hBB); set_wr(2, 6'd7, 8'hCC);
    apply_writes();
    tick();
    clear_wr();
    rd(6'd7, 6'd6, 6'd5, 6'd0);
    bus.I_OBUF_RD_VALID = 1'b0;
    chk("latency_stage1_only", 64'(bus.O_OBUF_WDATA_VALID), 64'd0);
    tick();
    chk("latency_word_valid", 64'(bus.O_OBUF_WDATA_VALID), 64'd1);
    drain();

    // Forwarding with a same-address write collision
    set_wr(0, 6'd9, 8'h11); set_wr(2, 6'd9, 8'h22);
    apply_writes();
    rd(6'd9, 6'd9, 6'd9, 6'd9);
    bus.I_OBUF_RD_VALID = 1'b0;
    clear_wr();
    drain();
    rd(6'd9, 6'd9, 6'd9, 6'd9);
    bus.I_OBUF_RD_VALID = 1'b0;
    drain();

    // A write after acceptance must not reach the captured pixels
    bus.I_OBUF_WDATA_READY = 1'b0;
    rd(6'd9, 6'd9, 6'd9, 6'd9);
    bus.I_OBUF_RD_VALID = 1'b0;
    set_wr(1, 6'd9, 8'h33);
    apply_writes();
    tick();
    clear_wr();
    tick();
    bus.I_OBUF_WDATA_READY = 1'b1;
    drain();
    rd(6'd9, 6'd9, 6'd9, 6'd9);
    bus.I_OBUF_RD_VALID = 1'b0;
    drain();

    // Backpressure: three reads against a stalled output
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N_WR; k++) set_wr(k, 6'(10 + 3*i + k), 8'(8'h40 + 3*i + k));
      apply_writes();
      tick();
    end
    clear_wr();
    bus.I_OBUF_WDATA_READY = 1'b0;
    rd(6'd10, 6'd11, 6'd12, 6'd13);
    rd(6'd14, 6'd15, 6'd16, 6'd17);
    bus.I_OBUF_RD_ADDR = {6'd21, 6'd20, 6'd19, 6'd18};
    for (int i = 0; i < 3; i++) begin
      chk("stall_rd_ready", 64'(bus.O_OBUF_RD_READY), 64'd0);
      chk("stall_valid_held", 64'(bus.O_OBUF_WDATA_VALID), 64'd1);
      tick();
    end
    bus.I_OBUF_WDATA_READY = 1'b1;
    rd(6'd18, 6'd19, 6'd20, 6'd21);
    bus.I_OBUF_RD_VALID = 1'b0;
    drain();

    // Clear while a word is held; then a restarted sweep
    bus.I_OBUF_WDATA_READY = 1'b0;
    rd(6'd5, 6'd12, 6'd9, 6'd20);
    bus.I_OBUF_RD_VALID = 1'b0;
    tick();
    chk("held_before_clr", 64'(bus.O_OBUF_WDATA_VALID), 64'd1);
    bus.I_OBUF_CLR = 1'b1;
    tick();
    bus.I_OBUF_CLR = 1'b0;
    chk("held_in_clear", 64'(bus.O_OBUF_WDATA_VALID), 64'd1);
    bus.I_OBUF_WDATA_READY = 1'b1;
    measure_busy(-1, 64, "clr1");
    drain();
    bus.I_OBUF_CLR = 1'b1;
    tick();
    bus.I_OBUF_CLR = 1'b0;
    measure_busy(9, 74, "clr2");

    // Every entry reads zero, at one request per cycle
    c0 = cyc;
    for (int i = 0; i < 16; i++) rd(6'(4*i), 6'(4*i + 1), 6'(4*i + 2), 6'(4*i + 3));
    bus.I_OBUF_RD_VALID = 1'b0;
    chk("stream_cycles", 64'(cyc - c0), 64'd16);
    drain();
    chk("addr_err_pow2", 64'(bus.O_OBUF_ADDR_ERR), 64'd0);

    // Out-of-range on the 48-entry instance
    chk("oor_err_before", 64'(bus48.O_OBUF_ADDR_ERR), 64'd0);
    bus48.I_OBUF_WR_EN   = 3'b011;
    bus48.I_OBUF_WR_ADDR = {6'd0, 6'd3, 6'd50};
    bus48.I_OBUF_WR_DATA = {8'h00, 8'h77, 8'h5A};
    tick();
    bus48.I_OBUF_WR_EN = '0;
    chk("oor_err_after_write", 64'(bus48.O_OBUF_ADDR_ERR), 64'd1);
    bus48.I_OBUF_RD_ADDR  = {6'd0, 6'd50, 6'd3, 6'd50};
    bus48.I_OBUF_RD_VALID = 1'b1;
    chk("oor_rd_ready", 64'(bus48.O_OBUF_RD_READY), 64'd1);
    tick();
    bus48.I_OBUF_RD_VALID = 1'b0;
    tick();
    chk("oor_word_valid", 64'(bus48.O_OBUF_WDATA_VALID), 64'd1);
    chk("oor_word", 64'(bus48.O_OBUF_WDATA), 64'h0000_0000_0077_0000);
    for (int i = 0; i < 5; i++) tick();
    chk("oor_err_sticky", 64'(bus48.O_OBUF_ADDR_ERR), 64'd1);

    // Reset clears the sticky flag and restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_oor_err", 64'(bus48.O_OBUF_ADDR_ERR), 64'd0);
    chk("rst2_clr_busy", 64'(bus.O_OBUF_CLR_BUSY), 64'd1);
    chk("rst2_rd_ready", 64'(bus.O_OBUF_RD_READY), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
